// File: rtl/etapa_fetch.sv
// Instruction-fetch stage: PC register, IF/ID pipeline register and a small
// START/RUN/HALT controller handling the post-reset start-up cycle and HALT words.
module etapa_fetch #(
  parameter int unsigned             PC_W      = 7,
  parameter int unsigned             INSTR_W   = 32,
  parameter int unsigned             RESET_PC  = 0,
  parameter logic [INSTR_W-1:0]      HALT_WORD = 32'hFFFF_FFFF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               stall,
  input  logic               branch_taken,
  input  logic [PC_W-1:0]    branch_target,
  output logic [PC_W-1:0]    pc,
  output logic               inc_en,
  input  logic [PC_W-1:0]    pc_inc,
  output logic [PC_W-1:0]    imem_addr,
  input  logic [INSTR_W-1:0] imem_data,
  output logic [INSTR_W-1:0] if_id_instr,
  output logic [PC_W-1:0]    if_id_pc,
  output logic               if_id_valid,
  output logic               halted
);

  typedef enum logic [1:0] {
    ST_START = 2'd0,
    ST_RUN   = 2'd1,
    ST_HALT  = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [PC_W-1:0]      pc_q, pc_d;
  logic [INSTR_W-1:0]   if_id_instr_q, if_id_instr_d;
  logic [PC_W-1:0]      if_id_pc_q, if_id_pc_d;
  logic                 if_id_valid_q, if_id_valid_d;
  logic                 is_halt_word_s;

  assign is_halt_word_s = (imem_data == HALT_WORD);

  // State and datapath registers; reset discards everything in flight
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= ST_START;
      pc_q          <= PC_W'(RESET_PC);
      if_id_instr_q <= {INSTR_W{1'b0}};
      if_id_pc_q    <= {PC_W{1'b0}};
      if_id_valid_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      if_id_instr_q <= if_id_instr_d;
      if_id_pc_q    <= if_id_pc_d;
      if_id_valid_q <= if_id_valid_d;
    end
  end

  // Next-state logic: branch beats stall; only a branch leaves HALT
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_START: state_d = ST_RUN;
      ST_RUN: begin
        if (branch_taken) begin
          state_d = ST_RUN;
        end else if (stall) begin
          state_d = ST_RUN;
        end else if (is_halt_word_s) begin
          state_d = ST_HALT;
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_HALT: begin
        if (branch_taken) begin
          state_d = ST_RUN;
        end else begin
          state_d = ST_HALT;
        end
      end
      default: state_d = ST_START;
    endcase
  end

  // PC and IF/ID next values; START holds everything while pc_inc settles
  always_comb begin
    pc_d          = pc_q;
    if_id_instr_d = if_id_instr_q;
    if_id_pc_d    = if_id_pc_q;
    if_id_valid_d = if_id_valid_q;
    case (state_q)
      ST_START: begin
        pc_d = pc_q;
      end
      ST_RUN: begin
        if (branch_taken) begin
          pc_d          = branch_target;
          if_id_valid_d = 1'b0;
        end else if (stall) begin
          pc_d = pc_q;
        end else begin
          // A HALT word is latched as valid but the PC parks on its address
          if (is_halt_word_s) begin
            pc_d = pc_q;
          end else begin
            pc_d = pc_inc;
          end
          if_id_instr_d = imem_data;
          if_id_pc_d    = pc_q;
          if_id_valid_d = 1'b1;
        end
      end
      ST_HALT: begin
        if (branch_taken) begin
          pc_d          = branch_target;
          if_id_valid_d = 1'b0;
        end else if (!stall) begin
          if_id_valid_d = 1'b0;
        end else begin
          pc_d = pc_q;
        end
      end
      default: begin
        pc_d          = PC_W'(RESET_PC);
        if_id_valid_d = 1'b0;
      end
    endcase
  end

  // Outputs decoded from the state register
  always_comb begin
    inc_en = 1'b1;
    halted = 1'b0;
    case (state_q)
      ST_START: begin
        inc_en = 1'b1;
        halted = 1'b0;
      end
      ST_RUN: begin
        inc_en = 1'b1;
        halted = 1'b0;
      end
      ST_HALT: begin
        inc_en = 1'b0;
        halted = 1'b1;
      end
      default: begin
        inc_en = 1'b0;
        halted = 1'b0;
      end
    endcase
  end

  assign pc          = pc_q;
  assign imem_addr   = pc_q;
  assign if_id_instr = if_id_instr_q;
  assign if_id_pc    = if_id_pc_q;
  assign if_id_valid = if_id_valid_q;

endmodule

// File: tb/tb_etapa_fetch.sv
// Directed bench for etapa_fetch with a falling-edge incrementer model and an
// instruction memory returning the zero-extended address (or HALT at one address).
module tb_etapa_fetch;

  logic        clk;
  logic        rst;
  logic        stall;
  logic        branch_taken;
  logic [6:0]  branch_target;
  logic [6:0]  pc;
  logic        inc_en;
  logic [6:0]  pc_inc;
  logic [6:0]  imem_addr;
  logic [31:0] imem_data;
  logic [31:0] if_id_instr;
  logic [6:0]  if_id_pc;
  logic        if_id_valid;
  logic        halted;

  logic        halt_en;
  logic [6:0]  halt_addr;
  int          checks;
  int          failures;

  etapa_fetch dut (
    .clk(clk), .rst(rst), .stall(stall), .branch_taken(branch_taken),
    .branch_target(branch_target), .pc(pc), .inc_en(inc_en), .pc_inc(pc_inc),
    .imem_addr(imem_addr), .imem_data(imem_data), .if_id_instr(if_id_instr),
    .if_id_pc(if_id_pc), .if_id_valid(if_id_valid), .halted(halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Incrementer stage model: registered pc+1 on the falling edge when enabled
  always @(negedge clk) begin
    if (inc_en) pc_inc <= pc + 7'd1;
  end

  assign imem_data = (halt_en && imem_addr == halt_addr) ? 32'hFFFF_FFFF : {25'h0, imem_addr};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_state(input string tag, input logic [6:0] e_pc, input logic e_valid,
                             input logic [6:0] e_ipc, input logic [31:0] e_instr,
                             input logic e_halted);
    check({tag, ".pc"}, {25'h0, pc}, {25'h0, e_pc});
    check({tag, ".valid"}, {31'h0, if_id_valid}, {31'h0, e_valid});
    if (e_valid) begin
      check({tag, ".if_id_pc"}, {25'h0, if_id_pc}, {25'h0, e_ipc});
      check({tag, ".instr"}, if_id_instr, e_instr);
    end
    check({tag, ".halted"}, {31'h0, halted}, {31'h0, e_halted});
    check({tag, ".inc_en"}, {31'h0, inc_en}, {31'h0, !e_halted});
  endtask

  initial begin
    checks = 0; failures = 0;
    rst = 1'b0; stall = 1'b0; branch_taken = 1'b0; branch_target = 7'd0;
    halt_en = 1'b0; halt_addr = 7'd7;

    repeat (2) step();
    check("rst.pc", {25'h0, pc}, 32'd0);
    check("rst.valid", {31'h0, if_id_valid}, 32'd0);
    check("rst.if_id_pc", {25'h0, if_id_pc}, 32'd0);
    check("rst.instr", if_id_instr, 32'd0);
    check("rst.halted", {31'h0, halted}, 32'd0);
    check("rst.imem_addr", {25'h0, imem_addr}, 32'd0);
    rst = 1'b1;

    // START cycle, then sequential fetch
    step(); check_state("start", 7'd0, 1'b0, 7'd0, 32'd0, 1'b0);
    step(); check_state("seq0", 7'd1, 1'b1, 7'd0, 32'd0, 1'b0);
    for (int i = 1; i < 5; i++) begin
      step(); check_state("seq", 7'(i + 1), 1'b1, 7'(i), 32'(i), 1'b0);
    end

    // Stall three cycles with pc=5
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step(); check_state("stall", 7'd5, 1'b1, 7'd4, 32'd4, 1'b0);
    end
    stall = 1'b0;
    for (int i = 5; i < 10; i++) begin
      step(); check_state("resume", 7'(i + 1), 1'b1, 7'(i), 32'(i), 1'b0);
    end

    // Branch plus stall in the same cycle at pc=10
    branch_taken = 1'b1; branch_target = 7'd40; stall = 1'b1;
    step(); check_state("br.flush", 7'd40, 1'b0, 7'd0, 32'd0, 1'b0);
    branch_taken = 1'b0; stall = 1'b0;
    step(); check_state("br.tgt", 7'd41, 1'b1, 7'd40, 32'd40, 1'b0);
    step(); check_state("br.next", 7'd42, 1'b1, 7'd41, 32'd41, 1'b0);

    // Wrap-around 126,127,0,1
    branch_taken = 1'b1; branch_target = 7'd126;
    step(); check_state("wrap.flush", 7'd126, 1'b0, 7'd0, 32'd0, 1'b0);
    branch_taken = 1'b0;
    step(); check_state("wrap126", 7'd127, 1'b1, 7'd126, 32'd126, 1'b0);
    step(); check_state("wrap127", 7'd0, 1'b1, 7'd127, 32'd127, 1'b0);
    step(); check_state("wrap0", 7'd1, 1'b1, 7'd0, 32'd0, 1'b0);
    step(); check_state("wrap1", 7'd2, 1'b1, 7'd1, 32'd1, 1'b0);

    // HALT word at address 7
    halt_en = 1'b1;
    for (int i = 2; i < 7; i++) begin
      step(); check_state("pre_halt", 7'(i + 1), 1'b1, 7'(i), 32'(i), 1'b0);
    end
    step(); check_state("halt.latch", 7'd7, 1'b1, 7'd7, 32'hFFFF_FFFF, 1'b1);
    step(); check_state("halt.bub", 7'd7, 1'b0, 7'd0, 32'd0, 1'b1);
    step(); check_state("halt.hold", 7'd7, 1'b0, 7'd0, 32'd0, 1'b1);
    branch_taken = 1'b1; branch_target = 7'd20;
    step(); check_state("halt.br", 7'd20, 1'b0, 7'd0, 32'd0, 1'b0);
    branch_taken = 1'b0;
    step(); check_state("halt.resume", 7'd21, 1'b1, 7'd20, 32'd20, 1'b0);
    step(); check_state("halt.resume2", 7'd22, 1'b1, 7'd21, 32'd21, 1'b0);

    // Asynchronous reset between edges
    #2;
    rst = 1'b0;
    #1;
    check("arst.pc", {25'h0, pc}, 32'd0);
    check("arst.valid", {31'h0, if_id_valid}, 32'd0);
    check("arst.halted", {31'h0, halted}, 32'd0);
    check("arst.if_id_pc", {25'h0, if_id_pc}, 32'd0);
    check("arst.instr", if_id_instr, 32'd0);
    rst = 1'b1;
    step(); check_state("arst.start", 7'd0, 1'b0, 7'd0, 32'd0, 1'b0);
    step(); check_state("arst.seq0", 7'd1, 1'b1, 7'd0, 32'd0, 1'b0);
    step(); check_state("arst.seq1", 7'd2, 1'b1, 7'd1, 32'd1, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/etapa_fetch.md
# etapa_fetch

Instruction-fetch stage of the pipeline: owns the program counter register, drives the PC incrementer stage and the instruction memory address, and loads the IF/ID pipeline register. It selects the next PC in this order: branch redirect, stall hold, then sequential increment. A small FSM handles the post-reset start-up cycle and a HALT word. Downstream stages consume `if_id_*`. The execute stage supplies the branch redirect and the hazard unit supplies the stall.

## Interface
- `PC_W`, 7: PC / instruction-memory address width (128 words).
- `INSTR_W`, 32: instruction width.
- `RESET_PC`, 0: PC value loaded on reset.
- `HALT_WORD`, 32'hFFFF_FFFF: instruction encoding that stops fetching.

- `clk`  in  1: single clock. The block uses the rising edge; the incrementer stage updates on the falling edge.
- `rst`  in  1: asynchronous, active-low reset (asserted = 0).
- `stall`  in  1: hazard unit holds the fetch and IF/ID stage.
- `branch_taken`  in  1: redirect request from the execute stage.
- `branch_target`  in  PC_W: redirect address.
- `pc`  out  PC_W: current PC, fed to the incrementer stage.
- `inc_en`  out  1: enable to the incrementer stage.
- `pc_inc`  in  PC_W: registered pc+1 returned by the incrementer stage. It is valid at a rising edge only if a falling edge with `inc_en`=1 occurred since `pc` last changed.
- `imem_addr`  out  PC_W: equal to `pc`. Instruction memory is combinational/asynchronous read.
- `imem_data`  in  INSTR_W: instruction at `imem_addr`.
- `if_id_instr`  out  INSTR_W: IF/ID instruction.
- `if_id_pc`  out  PC_W: PC of `if_id_instr`.
- `if_id_valid`  out  1: IF/ID holds a real instruction. When 0, it holds a bubble.
- `halted`  out  1: FSM is in HALT.

## Operation
- FSM states:
  - START (reset state).
  - RUN.
  - HALT.
- Reset (`rst`=0, asynchronous): state=START, `pc`=RESET_PC, `if_id_instr`=0, `if_id_pc`=0, `if_id_valid`=0, `halted`=0. The reset takes effect immediately, including mid-operation, and discards everything in flight.
- START:
  - `inc_en`=1 so that the incrementer computes RESET_PC+1 on the next falling edge.
  - At the first rising edge, the state goes to RUN. `pc` and IF/ID are unchanged (valid stays 0).
  - This cycle exists because `pc_inc` is not guaranteed valid at the first rising edge after reset release.
  - `branch_taken` and `stall` are ignored in START.
- RUN, evaluated at each rising edge in priority order:
  1. `branch_taken`=1: `pc`←`branch_target`; `if_id_valid`←0 (flush the wrong-path fetch). This wins over `stall`.
  2. `stall`=1: `pc`, IF/ID and state hold.
  3. Otherwise: `pc`←`pc_inc`; `if_id_instr`←`imem_data`; `if_id_pc`←`pc`; `if_id_valid`←1. If `imem_data`==HALT_WORD, the state goes to HALT: the HALT word is still latched with valid=1, and `pc` holds at the HALT address instead of advancing.
- HALT:
  - `halted`=1 and `inc_en`=0. `pc` holds.
  - At the first non-stalled rising edge, `if_id_valid`←0. After that it stays 0.
  - `branch_taken`=1 (an older branch resolving) means the HALT word was speculative: state goes to RUN, `pc`←`branch_target`, `if_id_valid`←0, `halted`←0.
  - Only reset or a branch leaves HALT.
- `inc_en`=1 in START and RUN, 0 in HALT.
- Arithmetic: PC is PC_W bits, unsigned, and wraps modulo 2^PC_W (127→0). No overflow flag is produced.
- `branch_target` is used as-is; no alignment check.

## Timing
- Fetch-to-IF/ID latency is 1 cycle: the instruction at `pc` in cycle n appears on `if_id_*` after rising edge n+1.
- First valid IF/ID appears after the second rising edge following reset release (START cycle plus fetch cycle).
- Branch penalty: 1 bubble. The flushed slot shows `if_id_valid`=0 for one cycle, then the target instruction arrives with valid=1.
- Stall holds `if_id_*` stable for its whole duration. Release resumes with no lost or duplicated instruction.
- Branch and stall in the same cycle: the branch is taken, IF/ID is flushed and the stall is ignored.
- `pc` changes only on rising edges. `pc_inc` settles at the following falling edge, before the next rising edge.

## Test plan
- Reset, then run with `imem_data`=`{25'h0,addr}` (instruction word = zero-extended address) and no stall or branch: `if_id_valid` is 0 for 2 cycles, then `if_id_pc` = 0,1,2,3… with matching instructions.
- Stall for 3 cycles while `pc`=5: `if_id_pc`=4 held for 3 cycles, then 5, 6 follow with no gap or repeat.
- `branch_taken`=1, `branch_target`=40 at `pc`=10, with `stall`=1 in the same cycle: next cycle `if_id_valid`=0 and `pc`=40; the cycle after, `if_id_pc`=40 with valid=1.
- Wrap-around: branch to 126 and run: `if_id_pc` sequence 126, 127, 0, 1.
- HALT_WORD at address 7: `if_id_pc`=7 with valid=1, then valid=0 with `halted`=1 and `pc` stuck at 7. A later `branch_taken` to 20 resumes fetch at 20 with `halted`=0.
- Assert `rst`=0 between clock edges mid-run: all outputs reset immediately (`pc`=0, valid=0, `halted`=0) without waiting for a clock edge. After release, the START cycle repeats.
